apb_timer: RTL and testbench
============================

Name: apb_timer

Overview:
- 32-bit down-counting timer peripheral on the APB side of the system bridge.
- Consumes the bridge's per-slave select (psel_sN) and the shared APB address, enable, write and write-data signals. Returns read data on that slave's prdata_sN input.
- Zero-wait-state APB slave: the bridge has no PREADY, so every access completes in its access phase.
- Provides a programmable prescaler, one-shot and periodic modes, and a maskable level interrupt.

Parameters:
- CNT_W, 32, width of the LOAD and VALUE registers and the down counter (8..32).
- PRE_W, 8, width of the prescaler field and the prescaler counter.

Ports:
- hclk  input  1  system clock; all state updates on the rising edge.
- hrst  input  1  synchronous active-high reset, sampled on the rising edge of hclk.
- psel  input  1  slave select from the bridge decode (psel_sN).
- penable  input  1  APB enable (apb_xx_penable).
- paddr  input  12  apb_xx_paddr[11:0]; the block uses paddr[4:2] only.
- pwrite  input  1  apb_xx_pwrite.
- pwdata  input  32  apb_xx_pwdata.
- prdata  output  32  read data to the bridge.
- timer_int  output  1  level interrupt, equal to raw_int AND int_en.

Behaviour:
- Write strobe wr = psel & penable & pwrite. Registers update at the end of the access phase. Writes in the setup phase (psel & !penable) have no effect.
- Read mux:
  - prdata is combinational from paddr[4:2] and register state.
  - prdata is driven when psel & !pwrite, otherwise 32'h0.
  - It is valid in both the setup and access phases.
  - Unmapped offsets read 0.
- Register map (byte offset):
  - 0x00 LOAD, RW, reset 0.
  - 0x04 VALUE, RO, reset 0. Writes are ignored.
  - 0x08 CTRL, RW, reset 0. Bit 0 en, bit 1 periodic, bit 2 int_en, bits [8+PRE_W-1:8] prescale. All other bits read 0.
  - 0x0C INTCLR, WO. Writing any value clears raw_int. Reads return 0.
  - 0x10 INTSTAT, RO. Bit 0 raw_int, bit 1 timer_int.
- Unused upper bits of CNT_W-wide registers read 0; write data above CNT_W is dropped.
- State machine, 2 states:
  - STOP: reset state. Entered when en=0.
  - RUN: entered when en=1.
  - STOP->RUN on a CTRL write with en=1. RUN->STOP on a CTRL write with en=0, or on one-shot expiry.
  - State always mirrors the en bit; hardware clears en on one-shot expiry.
- Prescaler:
  - pre_cnt (PRE_W bits) counts only in RUN.
  - tick = RUN & (pre_cnt == prescale). On tick, pre_cnt goes to 0; otherwise pre_cnt increments.
  - Counter period is therefore (prescale+1) hclk cycles. prescale=0 gives a tick every cycle.
  - pre_cnt is forced to 0 in STOP and on any LOAD write.
- Counter, on tick:
  - If VALUE != 0: VALUE decrements by 1.
  - If VALUE == 0 (expiry): raw_int is set to 1.
    - Periodic mode: VALUE reloads from LOAD and the timer stays in RUN.
    - One-shot mode: VALUE stays 0, en clears, and the state goes to STOP.
  - Periodic interval = (LOAD+1)*(prescale+1) cycles.
- LOAD write: LOAD and VALUE both take pwdata in the same edge, and pre_cnt clears. This is allowed in either state.
- Enabling with VALUE=0: the first tick expires immediately.
- Simultaneous events:
  - LOAD write and tick in the same cycle: the write wins; no decrement and no expiry that cycle.
  - INTCLR write and expiry in the same cycle: the set wins, so raw_int=1.
  - CTRL write with en=0 and tick in the same cycle: the tick is discarded and VALUE holds.
  - CTRL write with en=1 while already in RUN (e.g. a mode change): counting continues and pre_cnt is not cleared.
- timer_int is combinational from registered raw_int and int_en. Changing int_en masks or unmasks it without clearing raw_int.
- Reset (hrst=1 on an edge, including mid-count) gives:
  - state STOP
  - LOAD=0, VALUE=0, CTRL=0, pre_cnt=0
  - raw_int=0, timer_int=0, prdata=0
- There are no other outputs.

Test Plan:
- Reset then read all offsets 0x00-0x1C -> every read returns 32'h0 and timer_int=0.
- LOAD=5, CTRL=0x5 (en, one-shot, int_en, prescale 0) -> VALUE reads 4,3,2,1,0 on successive cycles. raw_int and timer_int rise 6 cycles after the CTRL write. CTRL reads 0x4 afterwards and VALUE stays 0.
- LOAD=2, CTRL=0x0307 (periodic, prescale 3) -> timer_int asserts every 12 cycles. Writing INTCLR deasserts timer_int for 11 cycles, then it reasserts.
- Periodic LOAD=0, prescale 0 -> an expiry every cycle. An INTCLR write on an expiry cycle leaves INTSTAT=0x3.
- Mid-count (VALUE=0x100), write LOAD=0x20 -> VALUE reads 0x20 the next cycle with no decrement that cycle. CTRL=0 then freezes VALUE.
- Assert hrst while running with raw_int=1 -> the next cycle VALUE=0, CTRL=0, timer_int=0. The counter stays stopped until CTRL is written.

Source files
------------

// File: rtl/apb_timer_if.sv
// APB slave-side bundle for the timer: the bridge's per-slave select, the shared
// address/enable/write/write-data signals and the returned read data.
interface apb_timer_if;
    logic        psel;
    logic        penable;
    logic [11:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  prdata
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output prdata
    );
endinterface

// File: rtl/apb_timer.sv
// Zero-wait-state APB down-counting timer with prescaler, one-shot/periodic
// modes and a maskable level interrupt.
module apb_timer #(
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic        hclk,
    input  logic        hrst,
    apb_timer_if.slave  apb,
    output logic        timer_int
);

    typedef enum logic [0:0] {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OFS_LOAD    = 3'd0;
    localparam logic [2:0] OFS_VALUE   = 3'd1;
    localparam logic [2:0] OFS_CTRL    = 3'd2;
    localparam logic [2:0] OFS_INTCLR  = 3'd3;
    localparam logic [2:0] OFS_INTSTAT = 3'd4;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   load_r;
    logic [CNT_W-1:0]   value_r;
    logic               periodic_r;
    logic               int_en_r;
    logic [PRE_W-1:0]   prescale_r;
    logic [PRE_W-1:0]   pre_cnt_r;
    logic               raw_int_r;

    logic [2:0]         addr_s;
    logic               wr_s;
    logic               load_wr_s;
    logic               ctrl_wr_s;
    logic               intclr_wr_s;
    logic               run_s;
    logic               tick_s;
    logic               count_tick_s;
    logic               expire_s;
    logic [31:0]        rdata_s;
    logic               unused_s;

    function automatic logic [31:0] zext_cnt(input logic [CNT_W-1:0] v);
        logic [31:0] r;
        r = 32'h0;
        r[CNT_W-1:0] = v;
        return r;
    endfunction

    function automatic logic [31:0] ctrl_word(input logic en, input logic periodic,
                                              input logic int_en,
                                              input logic [PRE_W-1:0] prescale);
        logic [31:0] r;
        r = 32'h0;
        r[0] = en;
        r[1] = periodic;
        r[2] = int_en;
        r[8+PRE_W-1:8] = prescale;
        return r;
    endfunction

    assign addr_s      = apb.paddr[4:2];
    assign wr_s        = apb.psel & apb.penable & apb.pwrite;
    assign load_wr_s   = wr_s & (addr_s == OFS_LOAD);
    assign ctrl_wr_s   = wr_s & (addr_s == OFS_CTRL);
    assign intclr_wr_s = wr_s & (addr_s == OFS_INTCLR);
    assign run_s       = (state_r == ST_RUN);
    assign tick_s      = run_s & (pre_cnt_r == prescale_r);

    // A LOAD write or a stopping CTRL write swallows a coincident tick.
    assign count_tick_s = tick_s & ~load_wr_s & ~(ctrl_wr_s & ~apb.pwdata[0]);
    assign expire_s     = count_tick_s & (value_r == {CNT_W{1'b0}});

    assign unused_s = &{1'b0, apb.paddr[11:5], apb.paddr[1:0], apb.pwdata};

    // State register.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_r <= ST_STOP;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: follows the en bit written via CTRL; one-shot expiry stops.
    always_comb begin
        state_next_s = state_r;
        if (ctrl_wr_s) begin
            state_next_s = apb.pwdata[0] ? ST_RUN : ST_STOP;
        end else if (expire_s && !periodic_r) begin
            state_next_s = ST_STOP;
        end else begin
            state_next_s = state_r;
        end
    end

    // CTRL mode and prescale fields.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            periodic_r <= 1'b0;
            int_en_r   <= 1'b0;
            prescale_r <= {PRE_W{1'b0}};
        end else if (ctrl_wr_s) begin
            periodic_r <= apb.pwdata[1];
            int_en_r   <= apb.pwdata[2];
            prescale_r <= apb.pwdata[8+PRE_W-1:8];
        end
    end

    // Prescaler: counts only in RUN, restarts on LOAD writes and after each tick.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            pre_cnt_r <= {PRE_W{1'b0}};
        end else if (load_wr_s || !run_s || tick_s) begin
            pre_cnt_r <= {PRE_W{1'b0}};
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
        end
    end

    // LOAD register.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            load_r <= {CNT_W{1'b0}};
        end else if (load_wr_s) begin
            load_r <= apb.pwdata[CNT_W-1:0];
        end
    end

    // Down counter: loads with LOAD writes, reloads on periodic expiry.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            value_r <= {CNT_W{1'b0}};
        end else if (load_wr_s) begin
            value_r <= apb.pwdata[CNT_W-1:0];
        end else if (count_tick_s) begin
            if (value_r != {CNT_W{1'b0}}) begin
                value_r <= value_r - CNT_W'(1);
            end else if (periodic_r) begin
                value_r <= load_r;
            end
        end
    end

    // Raw interrupt: expiry beats a coincident INTCLR write.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            raw_int_r <= 1'b0;
        end else if (expire_s) begin
            raw_int_r <= 1'b1;
        end else if (intclr_wr_s) begin
            raw_int_r <= 1'b0;
        end
    end

    // Read mux, valid in both setup and access phases.
    always_comb begin
        rdata_s = 32'h0;
        if (apb.psel && !apb.pwrite) begin
            case (addr_s)
                OFS_LOAD:    rdata_s = zext_cnt(load_r);
                OFS_VALUE:   rdata_s = zext_cnt(value_r);
                OFS_CTRL:    rdata_s = ctrl_word(run_s, periodic_r, int_en_r, prescale_r);
                OFS_INTSTAT: rdata_s = {30'h0, raw_int_r & int_en_r, raw_int_r};
                default:     rdata_s = 32'h0;
            endcase
        end else begin
            rdata_s = 32'h0;
        end
    end

    assign apb.prdata = rdata_s;
    assign timer_int  = raw_int_r & int_en_r;

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: register-access vector table plus hand-written
// counting, interrupt, collision and reset sequences.
module tb_apb_timer;

    logic hclk;
    logic hrst;
    logic timer_int;

    apb_timer_if bus ();

    apb_timer #(.CNT_W(32), .PRE_W(8)) dut (
        .hclk      (hclk),
        .hrst      (hrst),
        .apb       (bus.slave),
        .timer_int (timer_int)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic        do_wr;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];
    int   n_vec;
    int   n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at #1 after an edge; the write lands on the second edge, returns #1 after it.
    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = a; bus.pwdata = d;
        @(posedge hclk); #1;
        bus.penable = 1'b1;
        @(posedge hclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    // Setup-phase read: prdata is combinational, so no clock edge is consumed.
    task automatic peek(input logic [11:0] a, output logic [31:0] d);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
        #1;
        d = bus.prdata;
        bus.psel = 1'b0;
    endtask

    task automatic tick_wait(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge hclk); #1;
        end
    endtask

    logic [31:0] rd;

    initial begin
        n_vec = 0;
        n_bad = 0;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = 12'h0; bus.pwdata = 32'h0;
        hrst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b0, 12'h000, 32'h0, 12'(i * 4), 32'h0};
        end
        vecs[8]  = '{1'b1, 12'h000, 32'hDEADBEEF, 12'h000, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 12'h000, 32'h0,        12'h004, 32'hDEADBEEF};
        vecs[10] = '{1'b1, 12'h004, 32'h00000123, 12'h004, 32'hDEADBEEF};
        vecs[11] = '{1'b1, 12'h008, 32'hFFFFFFFE, 12'h008, 32'h0000FF06};
        vecs[12] = '{1'b0, 12'h000, 32'h0,        12'h00C, 32'h0};
        vecs[13] = '{1'b0, 12'h000, 32'h0,        12'h010, 32'h0};
        vecs[14] = '{1'b1, 12'h014, 32'hFFFFFFFF, 12'h014, 32'h0};
        vecs[15] = '{1'b1, 12'h008, 32'h0,        12'h008, 32'h0};
        vecs[16] = '{1'b1, 12'h000, 32'h0,        12'h004, 32'h0};

        tick_wait(2);
        @(posedge hclk); #1;
        hrst = 1'b0;
        check("reset_timer_int", {31'h0, timer_int}, 32'h0);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].do_wr) apb_write(vecs[i].waddr, vecs[i].wdata);
            peek(vecs[i].raddr, rd);
            check($sformatf("vec%0d_rd_0x%03h", i, vecs[i].raddr), rd, vecs[i].exp);
        end

        // Setup phase alone must not write.
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 12'h000; bus.pwdata = 32'h55;
        @(posedge hclk); #1;
        bus.psel = 1'b0; bus.pwrite = 1'b0;
        peek(12'h000, rd);
        check("setup_only_write", rd, 32'h0);

        // One-shot, prescale 0.
        apb_write(12'h000, 32'd5);
        apb_write(12'h008, 32'h5);
        for (int k = 1; k <= 5; k++) begin
            tick_wait(1);
            peek(12'h004, rd);
            check($sformatf("oneshot_value_%0d", k), rd, 32'(5 - k));
            check($sformatf("oneshot_int_low_%0d", k), {31'h0, timer_int}, 32'h0);
        end
        tick_wait(1);
        check("oneshot_int_high", {31'h0, timer_int}, 32'h1);
        peek(12'h010, rd); check("oneshot_intstat", rd, 32'h3);
        peek(12'h008, rd); check("oneshot_ctrl_en_cleared", rd, 32'h4);
        tick_wait(2);
        peek(12'h004, rd); check("oneshot_value_held", rd, 32'h0);
        apb_write(12'h00C, 32'h0);
        check("intclr_clears", {31'h0, timer_int}, 32'h0);

        // Periodic LOAD=2, prescale 3: expiry every 12 cycles.
        apb_write(12'h000, 32'd2);
        apb_write(12'h008, 32'h0307);
        for (int k = 1; k <= 12; k++) begin
            tick_wait(1);
            check($sformatf("periodic_int_c%0d", k), {31'h0, timer_int}, (k == 12) ? 32'h1 : 32'h0);
        end
        apb_write(12'h00C, 32'h0);
        check("periodic_intclr", {31'h0, timer_int}, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            tick_wait(1);
            check($sformatf("periodic_reassert_c%0d", k), {31'h0, timer_int}, (k == 10) ? 32'h1 : 32'h0);
        end
        apb_write(12'h008, 32'h0303);
        peek(12'h010, rd); check("mask_keeps_raw", rd, 32'h1);
        check("mask_timer_int", {31'h0, timer_int}, 32'h0);
        apb_write(12'h008, 32'h0);

        // Periodic LOAD=0: expiry every cycle; INTCLR on an expiry loses.
        apb_write(12'h000, 32'd0);
        apb_write(12'h008, 32'h7);
        tick_wait(2);
        apb_write(12'h00C, 32'h0);
        peek(12'h010, rd); check("intclr_vs_expiry", rd, 32'h3);
        apb_write(12'h008, 32'h0);
        apb_write(12'h00C, 32'h0);

        // LOAD write mid-count, then CTRL=0 freezes.
        apb_write(12'h000, 32'h100);
        apb_write(12'h008, 32'h1);
        tick_wait(3);
        peek(12'h004, rd); check("midcount_value", rd, 32'hFD);
        apb_write(12'h000, 32'h20);
        peek(12'h004, rd); check("load_beats_tick", rd, 32'h20);
        tick_wait(1);
        peek(12'h004, rd); check("after_load_dec", rd, 32'h1F);
        apb_write(12'h008, 32'h0);
        peek(12'h004, rd); check("stop_discards_tick", rd, 32'h1E);
        tick_wait(2);
        peek(12'h004, rd); check("stopped_frozen", rd, 32'h1E);

        // Reset while running with raw_int set.
        apb_write(12'h000, 32'd3);
        apb_write(12'h008, 32'h7);
        tick_wait(6);
        check("pre_reset_int", {31'h0, timer_int}, 32'h1);
        hrst = 1'b1;
        @(posedge hclk); #1;
        hrst = 1'b0;
        peek(12'h004, rd); check("rst_value", rd, 32'h0);
        peek(12'h008, rd); check("rst_ctrl", rd, 32'h0);
        peek(12'h000, rd); check("rst_load", rd, 32'h0);
        check("rst_timer_int", {31'h0, timer_int}, 32'h0);
        tick_wait(3);
        peek(12'h010, rd); check("rst_stays_stopped", rd, 32'h0);

        // Enabling with VALUE=0 expires on the first tick.
        apb_write(12'h008, 32'h1);
        tick_wait(1);
        peek(12'h010, rd); check("en_zero_expires", rd, 32'h1);
        peek(12'h008, rd); check("en_zero_stops", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
